// File: rtl/usb2_ts_pkg.sv
// Shared TS framing constants and packer state encoding for the EP3 bulk-IN feeder.
package usb2_ts_pkg;

  localparam int unsigned TS_PKT_LEN   = 188;
  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;
  localparam logic [7:0]  TS_LAST_IDX  = 8'(TS_PKT_LEN - 1);

  typedef enum logic [1:0] {
    S_WAIT_READY = 2'd0,
    S_FILL       = 2'd1,
    S_COMMIT     = 2'd2
  } pk_state_t;

  function automatic logic [10:0] pkt_bytes(input logic [3:0] n);
    return 11'(n) * 11'(TS_PKT_LEN);
  endfunction

endpackage

// File: rtl/usb2_ts_framer.sv
// TS framing checker: tracks byte index, decides per byte write/ignore/drop; decisions are combinational.
// No backpressure: the packer says via can_write whether a new packet may land, otherwise it is dropped.
module usb2_ts_framer
  import usb2_ts_pkg::*;
(
  input  logic       ext_clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [7:0] ts_data,
  input  logic       ts_valid,
  input  logic       ts_start,
  input  logic       can_write,
  output logic       wr_vld,
  output logic [7:0] wr_idx,
  output logic [7:0] wr_dat,
  output logic       pkt_done,
  output logic       idx_zero,
  output logic       drop,
  output logic       sync_err
);

  logic [7:0] idx, idx_nxt;
  logic       skip, skip_nxt;
  logic       stale, stale_nxt;
  logic       acc, bad_sync, lost;

  assign acc      = ts_valid & enable;
  assign bad_sync = (ts_data != TS_SYNC_BYTE);
  assign lost     = (idx != 8'd0);
  assign idx_zero = ~lost;
  assign wr_dat   = ts_data;

  // stale: enable dropped mid-packet; the remainder is ignored and the packet
  // is counted as lost (without a sync error) when the next start arrives.
  always_comb begin
    wr_vld    = 1'b0;
    wr_idx    = idx;
    pkt_done  = 1'b0;
    drop      = 1'b0;
    sync_err  = 1'b0;
    idx_nxt   = idx;
    skip_nxt  = skip;
    stale_nxt = stale | (~enable & lost);
    if (acc) begin
      if (ts_start) begin
        drop      = lost | bad_sync | ~can_write;
        sync_err  = (lost & ~stale) | bad_sync;
        stale_nxt = 1'b0;
        if (!bad_sync && can_write) begin
          wr_vld   = 1'b1;
          wr_idx   = 8'd0;
          idx_nxt  = 8'd1;
          skip_nxt = 1'b0;
        end else begin
          idx_nxt  = 8'd0;
          skip_nxt = 1'b1;
        end
      end else if (!(skip || stale)) begin
        if (!lost) begin
          drop     = 1'b1;
          sync_err = 1'b1;
          skip_nxt = 1'b1;
        end else begin
          wr_vld = 1'b1;
          if (idx == TS_LAST_IDX) begin
            pkt_done = 1'b1;
            idx_nxt  = 8'd0;
          end else begin
            idx_nxt = idx + 8'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge ext_clk) begin
    if (!reset_n) begin
      idx   <= 8'd0;
      skip  <= 1'b0;
      stale <= 1'b0;
    end else begin
      idx   <= idx_nxt;
      skip  <= skip_nxt;
      stale <= stale_nxt;
    end
  end

endmodule

// File: rtl/usb2_ts_ep3_packer.sv
// Packs whole TS packets into the EP3 IN buffer, committing on packet quota or idle timeout; writes lag input by one cycle.
// No input backpressure: packets that cannot be buffered are dropped whole and counted; commit is held until acked.
module usb2_ts_ep3_packer
  import usb2_ts_pkg::*;
#(
  parameter int unsigned PKTS_PER_XFER = 10,
  parameter int unsigned TIMEOUT       = 65535,
  parameter int unsigned DROP_W        = 16
) (
  input  logic              ext_clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [7:0]        ts_data,
  input  logic              ts_valid,
  input  logic              ts_start,
  output logic [10:0]       buf_in_addr,
  output logic [7:0]        buf_in_data,
  output logic              buf_in_wren,
  input  logic              buf_in_ready,
  output logic              buf_in_commit,
  output logic [10:0]       buf_in_commit_len,
  input  logic              buf_in_commit_ack,
  output logic [DROP_W-1:0] stat_drop_cnt,
  output logic              stat_sync_err
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  pk_state_t   state;
  logic [3:0]  pkt_cnt;
  logic [10:0] base;
  logic [TW-1:0] timer;

  logic       wr_vld, pkt_done, idx_zero, drop, sync_err;
  logic [7:0] wr_idx, wr_dat;
  logic       acc, quota, idle_out, go_commit, can_write;

  assign acc      = ts_valid & enable;
  assign quota    = (pkt_cnt == 4'(PKTS_PER_XFER));
  assign idle_out = (TIMEOUT != 0) && (pkt_cnt != 4'd0) && idx_zero &&
                    (timer == TW'(TIMEOUT - 1));
  assign go_commit = (state == S_FILL) && (quota || idle_out);
  // A start byte seen in the cycle that leaves S_FILL is treated as unbufferable.
  assign can_write = (state == S_FILL) && !go_commit;

  usb2_ts_framer u_framer (
    .ext_clk   (ext_clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .ts_data   (ts_data),
    .ts_valid  (ts_valid),
    .ts_start  (ts_start),
    .can_write (can_write),
    .wr_vld    (wr_vld),
    .wr_idx    (wr_idx),
    .wr_dat    (wr_dat),
    .pkt_done  (pkt_done),
    .idx_zero  (idx_zero),
    .drop      (drop),
    .sync_err  (sync_err)
  );

  always_ff @(posedge ext_clk) begin
    if (!reset_n) begin
      state             <= S_WAIT_READY;
      pkt_cnt           <= 4'd0;
      base              <= 11'd0;
      timer             <= '0;
      buf_in_addr       <= 11'd0;
      buf_in_data       <= 8'd0;
      buf_in_wren       <= 1'b0;
      buf_in_commit     <= 1'b0;
      buf_in_commit_len <= 11'd0;
      stat_drop_cnt     <= '0;
      stat_sync_err     <= 1'b0;
    end else begin
      buf_in_wren   <= wr_vld;
      stat_sync_err <= sync_err;
      if (wr_vld) begin
        buf_in_addr <= base + 11'(wr_idx);
        buf_in_data <= wr_dat;
      end
      if (drop && (stat_drop_cnt != '1))
        stat_drop_cnt <= stat_drop_cnt + DROP_W'(1);
      // Idle timer only counts at a packet boundary with something to flush.
      if ((state == S_FILL) && (pkt_cnt != 4'd0) && idx_zero && !acc)
        timer <= timer + TW'(1);
      else
        timer <= '0;
      if (pkt_done) begin
        pkt_cnt <= pkt_cnt + 4'd1;
        base    <= base + 11'(TS_PKT_LEN);
      end
      case (state)
        S_WAIT_READY: if (buf_in_ready) state <= S_FILL;
        S_FILL: begin
          if (go_commit) begin
            state             <= S_COMMIT;
            buf_in_commit     <= 1'b1;
            buf_in_commit_len <= pkt_bytes(pkt_cnt);
          end
        end
        S_COMMIT: begin
          if (buf_in_commit_ack) begin
            state         <= S_WAIT_READY;
            buf_in_commit <= 1'b0;
            pkt_cnt       <= 4'd0;
            base          <= 11'd0;
            buf_in_addr   <= 11'd0;
          end
        end
        default: state <= S_WAIT_READY;
      endcase
    end
  end

endmodule

// File: tb/tb_usb2_ts_ep3_packer.sv
// Directed bench for the EP3 TS packer: scoreboarded buffer writes plus commit/drop/sync checks.
module tb_usb2_ts_ep3_packer;

  logic        ext_clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [7:0]  ts_data;
  logic        ts_valid;
  logic        ts_start;
  logic [10:0] buf_in_addr;
  logic [7:0]  buf_in_data;
  logic        buf_in_wren;
  logic        buf_in_ready;
  logic        buf_in_commit;
  logic [10:0] buf_in_commit_len;
  logic        buf_in_commit_ack;
  logic [15:0] stat_drop_cnt;
  logic        stat_sync_err;

  typedef struct packed {
    logic [10:0] a;
    logic [7:0]  d;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  checks = 0;
  int  errors = 0;
  int  sync_pulses = 0;
  int  wr_count = 0;
  int  exp_drop = 0;
  int  cyc;

  always #5 ext_clk = ~ext_clk;

  usb2_ts_ep3_packer #(
    .PKTS_PER_XFER (10),
    .TIMEOUT       (100),
    .DROP_W        (16)
  ) dut (
    .ext_clk           (ext_clk),
    .reset_n           (reset_n),
    .enable            (enable),
    .ts_data           (ts_data),
    .ts_valid          (ts_valid),
    .ts_start          (ts_start),
    .buf_in_addr       (buf_in_addr),
    .buf_in_data       (buf_in_data),
    .buf_in_wren       (buf_in_wren),
    .buf_in_ready      (buf_in_ready),
    .buf_in_commit     (buf_in_commit),
    .buf_in_commit_len (buf_in_commit_len),
    .buf_in_commit_ack (buf_in_commit_ack),
    .stat_drop_cnt     (stat_drop_cnt),
    .stat_sync_err     (stat_sync_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge ext_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input bit st);
    ts_data  = d;
    ts_valid = 1'b1;
    ts_start = st;
    step();
    ts_valid = 1'b0;
    ts_start = 1'b0;
  endtask

  task automatic send_pkt(input logic [10:0] base, input bit wr, input int n,
                          input logic [7:0] first, input int seed, input int ready_at);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      d = (i == 0) ? first : 8'(i * 3 + seed);
      if (i == ready_at) buf_in_ready = 1'b1;
      if (wr) exp_q.push_back('{a: base + 11'(i), d: d});
      send_byte(d, i == 0);
    end
  endtask

  task automatic wait_commit(input int limit, output int n);
    n = 0;
    while (!buf_in_commit && n < limit) begin
      step();
      n++;
    end
    check("commit_rise", 32'(buf_in_commit), 32'd1);
  endtask

  // Write monitor: every buffer write must match the next expected write.
  always @(negedge ext_clk) begin
    if (stat_sync_err) sync_pulses++;
    if (buf_in_wren) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("wr_unexpected_qlen", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(buf_in_addr), 32'(mon_e.a));
        check("wr_data", 32'(buf_in_data), 32'(mon_e.d));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b1; ts_data = 8'd0; ts_valid = 1'b0; ts_start = 1'b0;
    buf_in_ready = 1'b0; buf_in_commit_ack = 1'b0;
    repeat (3) step();
    check("rst_wren", 32'(buf_in_wren), 32'd0);
    check("rst_addr", 32'(buf_in_addr), 32'd0);
    check("rst_data", 32'(buf_in_data), 32'd0);
    check("rst_commit", 32'(buf_in_commit), 32'd0);
    check("rst_len", 32'(buf_in_commit_len), 32'd0);
    check("rst_drop", 32'(stat_drop_cnt), 32'd0);
    check("rst_sync", 32'(stat_sync_err), 32'd0);

    // Full quota of back-to-back packets.
    reset_n = 1'b1; buf_in_ready = 1'b1;
    step(); step();
    for (int k = 0; k < 10; k++) send_pkt(11'(k * 188), 1'b1, 188, 8'h47, k, -1);
    check("last_wren", 32'(buf_in_wren), 32'd1);
    check("last_addr", 32'(buf_in_addr), 32'd1879);
    check("commit_after_wr", 32'(buf_in_commit), 32'd0);
    step();
    check("quota_commit", 32'(buf_in_commit), 32'd1);
    check("quota_len", 32'(buf_in_commit_len), 32'd1880);
    check("quota_q_empty", 32'(exp_q.size()), 32'd0);
    check("quota_wr_count", 32'(wr_count), 32'd1880);
    repeat (3) step();
    check("commit_held", 32'(buf_in_commit), 32'd1);
    check("commit_len_stable", 32'(buf_in_commit_len), 32'd1880);
    buf_in_ready = 1'b0; buf_in_commit_ack = 1'b1;
    step();
    buf_in_commit_ack = 1'b0;
    check("ack_commit_low", 32'(buf_in_commit), 32'd0);
    check("ack_addr_clr", 32'(buf_in_addr), 32'd0);

    // Packets with no free buffer are dropped once each.
    send_pkt(11'd0, 1'b0, 188, 8'h47, 20, -1);
    send_pkt(11'd0, 1'b0, 188, 8'h47, 21, -1);
    exp_drop = 2;
    check("noready_drop", 32'(stat_drop_cnt), 32'(exp_drop));
    check("noready_sync", 32'(sync_pulses), 32'd0);
    check("noready_wr_count", 32'(wr_count), 32'd1880);

    // Ready rises mid-packet: that packet stays dropped, writing resumes at the next start.
    send_pkt(11'd0, 1'b0, 188, 8'h47, 30, 50);
    exp_drop = 3;
    check("midready_drop", 32'(stat_drop_cnt), 32'(exp_drop));
    send_pkt(11'd0,   1'b1, 188, 8'h47, 31, -1);
    send_pkt(11'd188, 1'b1, 188, 8'h47, 32, -1);
    send_pkt(11'd376, 1'b1, 188, 8'h47, 33, -1);
    repeat (90) step();
    check("no_early_flush", 32'(buf_in_commit), 32'd0);
    send_pkt(11'd564, 1'b1, 188, 8'h47, 34, -1);
    wait_commit(200, cyc);
    check("timeout_latency", 32'(cyc), 32'd100);
    check("timeout_len", 32'(buf_in_commit_len), 32'd752);
    check("timeout_q_empty", 32'(exp_q.size()), 32'd0);
    buf_in_commit_ack = 1'b1;
    step();
    buf_in_commit_ack = 1'b0;
    check("ack2_commit_low", 32'(buf_in_commit), 32'd0);
    step(); step();

    // Bad sync byte on a start.
    send_pkt(11'd0,   1'b1, 188, 8'h47, 40, -1);
    send_pkt(11'd0,   1'b0, 188, 8'h46, 41, -1);
    send_pkt(11'd188, 1'b1, 188, 8'h47, 42, -1);
    exp_drop = 4;
    check("badsync_drop", 32'(stat_drop_cnt), 32'(exp_drop));
    check("badsync_pulse", 32'(sync_pulses), 32'd1);

    // Start inside a packet rewinds to the packet base.
    send_pkt(11'd376, 1'b1, 50,  8'h47, 50, -1);
    send_pkt(11'd376, 1'b1, 188, 8'h47, 51, -1);
    exp_drop = 5;
    check("earlystart_drop", 32'(stat_drop_cnt), 32'(exp_drop));
    check("earlystart_pulse", 32'(sync_pulses), 32'd2);

    // Enable falls mid-packet: rest ignored, dropped at the next start without sync error.
    send_pkt(11'd564, 1'b1, 100, 8'h47, 60, -1);
    enable = 1'b0;
    repeat (3) send_byte(8'hAA, 1'b0);
    enable = 1'b1;
    for (int i = 0; i < 88; i++) send_byte(8'(i), 1'b0);
    check("stale_hold_drop", 32'(stat_drop_cnt), 32'(exp_drop));
    send_pkt(11'd564, 1'b1, 188, 8'h47, 61, -1);
    exp_drop = 6;
    check("stale_drop", 32'(stat_drop_cnt), 32'(exp_drop));
    check("stale_no_pulse", 32'(sync_pulses), 32'd2);

    // Reset while commit is held.
    wait_commit(200, cyc);
    check("flush2_latency", 32'(cyc), 32'd100);
    check("flush2_len", 32'(buf_in_commit_len), 32'd752);
    check("flush2_q_empty", 32'(exp_q.size()), 32'd0);
    reset_n = 1'b0;
    step();
    check("rstc_commit", 32'(buf_in_commit), 32'd0);
    check("rstc_addr", 32'(buf_in_addr), 32'd0);
    check("rstc_drop", 32'(stat_drop_cnt), 32'd0);
    check("rstc_wren", 32'(buf_in_wren), 32'd0);
    reset_n = 1'b1;
    step(); step();

    // Non-start byte at a packet boundary is a framing error.
    send_byte(8'h12, 1'b0);
    check("stray_pulse", 32'(stat_sync_err), 32'd1);
    check("stray_drop", 32'(stat_drop_cnt), 32'd1);
    step();
    check("stray_pulse_end", 32'(stat_sync_err), 32'd0);
    send_pkt(11'd0, 1'b1, 188, 8'h47, 70, -1);
    repeat (3) step();
    check("final_q_empty", 32'(exp_q.size()), 32'd0);
    check("final_pulses", 32'(sync_pulses), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb2_ts_ep3_packer.md
Name: usb2_ts_ep3_packer

Overview:
Upstream feeder for the EP3 bulk-IN transport-stream buffer of the USB 2.0 core. It accepts a byte-wide MPEG-TS stream with a packet-start strobe and validates 188-byte packet framing. It packs whole packets into the EP3 endpoint buffer and commits a transfer when it reaches a packet quota or when the stream goes idle. Partial, corrupt or un-bufferable packets are discarded and counted, so the host only ever receives whole, sync-aligned TS packets.

Parameters:
PKTS_PER_XFER, 10, whole TS packets per commit; PKTS_PER_XFER*188 must be ≤ 2047 (default gives 1880 bytes).
TIMEOUT, 65535, idle cycles at a packet boundary before a partial transfer is flushed; 0 disables flushing.
DROP_W, 16, width of the drop counter.

Ports:
ext_clk  in  1  block clock; same clock as the EP3 buffer write port.
reset_n  in  1  reset; synchronous, active-low.
enable  in  1  when low, input bytes are ignored; a packet in progress is discarded at the next start.
ts_data  in  8  TS byte.
ts_valid  in  1  ts_data is valid this cycle.
ts_start  in  1  qualifies a valid byte as the first byte of a packet.
buf_in_addr  out  11  EP3 buffer write address.
buf_in_data  out  8  EP3 buffer write data.
buf_in_wren  out  1  EP3 buffer write strobe.
buf_in_ready  in  1  an EP3 buffer is free for writing.
buf_in_commit  out  1  commit request, level, held until acknowledged.
buf_in_commit_len  out  11  byte length of the committed transfer.
buf_in_commit_ack  in  1  commit accepted.
stat_drop_cnt  out  DROP_W  count of discarded packets, saturating.
stat_sync_err  out  1  one-cycle pulse when a packet is discarded for a framing error.

Behaviour:
- Reset state: all outputs 0; state S_WAIT_READY; byte index, packet count, base address, timer and drop flag all cleared.
- States:
  - S_WAIT_READY: go to S_FILL when buf_in_ready=1.
  - S_FILL: accept bytes; go to S_COMMIT on quota or timeout.
  - S_COMMIT: hold buf_in_commit=1 with a stable buf_in_commit_len; on the first cycle buf_in_commit_ack=1, drive commit to 0, clear the packet count, base and address, and go to S_WAIT_READY.
- Acceptance: a byte is accepted when ts_valid=1 and enable=1. The accepted byte appears on buf_in_data/buf_in_addr with buf_in_wren=1 exactly one cycle later (registered).
- Packet start: a byte with ts_start=1 and data 0x47 starts a packet at addr = base (= pkt_cnt*188). The byte index runs 0..187.
- Framing errors, each discarding the packet in progress (address rewinds to base, drop_cnt+1, stat_sync_err pulse):
  - ts_start=1 with index≠0.
  - ts_start=1 with data≠0x47.
  - a valid byte without ts_start while index=0.
- After a framing error, non-start bytes are ignored until the next valid start. A bad start byte is not written.
- Packet completion: on the accepted byte at index 187, pkt_cnt increments, base advances by 188 and index returns to 0.
- Quota: when pkt_cnt reaches PKTS_PER_XFER, go to S_COMMIT with len=PKTS_PER_XFER*188. This happens in the cycle after the last write, so the final wren completes before commit rises.
- Timeout: the timer runs only in S_FILL with pkt_cnt>0 and index=0, and clears on any accepted byte. When it reaches TIMEOUT-1, go to S_COMMIT with len=pkt_cnt*188. The timer never flushes a partial packet.
- Bytes in S_WAIT_READY or S_COMMIT are never written. The packet they belong to is marked dropped, all its bytes are ignored, and drop_cnt increments once at its start byte.
- A start byte that arrives in the same cycle as the S_FILL→S_COMMIT transition belongs to the dropped case.
- enable falling mid-packet discards that packet when the next start arrives (counted as a drop, no sync_err).
- stat_drop_cnt saturates at all-ones.
- The write address never exceeds PKTS_PER_XFER*188-1; all length arithmetic is 11-bit.
- reset_n=0 in any state, including mid-commit, returns to the reset state on the next edge.

Decomposition:
- Shared package usb2_ts_pkg: TS_PKT_LEN=188, TS_SYNC_BYTE=8'h47, and the packer state enum.
- Sub-module usb2_ts_framer handles sync/index checking and the drop decision, emitting accepted byte, index, packet-done and error strobes.
- The top level holds the FSM, addressing, timer and commit handshake.

Test Plan:
- Ready=1, 10 clean packets back-to-back → 1880 writes at addr 0..1879, then commit with len=1880; ack after 3 cycles → commit falls the cycle after ack, and the FSM waits for ready.
- TIMEOUT=100, 3 packets then idle → commit len=564 exactly 100 cycles after the last byte; a 4th packet started before the timeout expires → no flush.
- Second packet begins with 0x46 → no write, sync_err pulse, drop_cnt=1; the next good packet is written at addr 188.
- ts_start at index 50 of packet 2 → addr rewinds to 188, drop_cnt=1, and the new packet is written from 188.
- Packets arriving while ready=0 or during commit → no wren, drop_cnt increments once per packet; ready=1 mid-packet → writing resumes only at the next start.
- reset_n=0 while commit is held → commit=0, addr=0 and drop_cnt=0 on the next edge.
